// File: rtl/eth_frame_tx_if.sv
// eth_frame_tx_if: payload byte stream in and framed MAC byte stream out of the Ethernet framer
interface eth_frame_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_sof;
  logic       m_eof;
  modport master (output s_data, s_valid, s_last, input s_ready, m_data, m_valid, m_sof, m_eof);
  modport slave  (input s_data, s_valid, s_last, output s_ready, m_data, m_valid, m_sof, m_eof);
endinterface

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: byte-serial Ethernet II framer (preamble, header, payload, pad, IFG); define ETH_TX_FCS_EN to append CRC-32 FCS
module eth_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'h01_00_5E_00_00_01,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h0800,
  parameter bit          VLAN_TAG_EN = 1'b0,
  parameter logic [11:0] VLAN_VID    = 12'd1,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_CYCLES  = 12
) (
  input  logic          clk,
  input  logic          rst,
  eth_frame_tx_if.slave bus,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          err_oversize
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_IFG  = 3'd6;
`ifdef ETH_TX_FCS_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif
  localparam logic [10:0] HDR_LAST = VLAN_TAG_EN ? 11'd17 : 11'd13;
  localparam logic [10:0] MIN_LEN  = VLAN_TAG_EN ? 11'd42 : 11'd46;
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);
  // Header packed MSB-first; the untagged form is left-aligned so byte i sits at the same offset in both
  localparam logic [143:0] HDR = VLAN_TAG_EN ? {DST_MAC, SRC_MAC, 16'h8100, 4'h0, VLAN_VID, ETHERTYPE}
                                             : {DST_MAC, SRC_MAC, ETHERTYPE, 32'h0};

  logic [2:0]  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_sof_q, m_sof_d;
  logic        m_eof_q, m_eof_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        close, finish;
  logic [4:0]  hdr_sel;
  logic [7:0]  hdr_byte, fcs_byte;

  assign hdr_sel  = 5'd17 - cnt_q[4:0];
  assign hdr_byte = 8'(HDR >> {hdr_sel, 3'b000});

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic        crc_en;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  assign crc_en   = m_valid_d && (state_q inside {S_HDR, S_PAY, S_PAD});
  assign fcs_byte = 8'(~crc_q >> {cnt_q[1:0], 3'b000});

  // CRC runs over every header/payload/pad byte as it leaves; reloaded while idle
  always_comb crc_d = (state_q == S_IDLE) ? '1 : crc_en ? crc8(crc_q, m_data_d) : crc_q;

  // CRC register
  always_ff @(posedge clk or posedge rst)
    if (rst) crc_q <= '1;
    else crc_q <= crc_d;
`else
  assign fcs_byte = 8'h00;
`endif

  // Frame sequencer: picks the byte to register onto m_data this cycle and the next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    m_data_d  = 8'h00;
    m_valid_d = 1'b0;
    m_sof_d   = 1'b0;
    m_eof_d   = 1'b0;
    err_d     = 1'b0;
    close     = 1'b0;
    finish    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.s_valid) begin
        state_d   = S_PRE;
        cnt_d     = 11'd1;
        m_data_d  = 8'h55;
        m_valid_d = 1'b1;
        m_sof_d   = 1'b1;
      end
      S_PRE: begin
        m_valid_d = 1'b1;
        m_data_d  = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
        cnt_d     = (cnt_q == 11'd7) ? 11'd0 : cnt_q + 11'd1;
        state_d   = (cnt_q == 11'd7) ? S_HDR : S_PRE;
      end
      S_HDR: begin
        m_valid_d = 1'b1;
        m_data_d  = hdr_byte;
        cnt_d     = (cnt_q == HDR_LAST) ? 11'd0 : cnt_q + 11'd1;
        state_d   = (cnt_q == HDR_LAST) ? S_PAY : S_HDR;
      end
      S_PAY: begin
        // Byte MAX_LEN is held back so it can carry the frame end once s_last of an oversize packet arrives
        m_valid_d = !bus.s_valid || cnt_q < MAX_LEN - 11'd1 || bus.s_last;
        m_data_d  = !bus.s_valid ? 8'h00 : (cnt_q == MAX_LEN) ? hold_q : bus.s_data;
        cnt_d     = (bus.s_valid && cnt_q < MAX_LEN) ? cnt_q + 11'd1 : cnt_q;
        hold_d    = (bus.s_valid && cnt_q == MAX_LEN - 11'd1) ? bus.s_data : hold_q;
        err_d     = bus.s_valid && bus.s_last && cnt_q == MAX_LEN;
        close     = bus.s_valid && bus.s_last;
        state_d   = (close && cnt_d < MIN_LEN) ? S_PAD : S_PAY;
        finish    = close && cnt_d >= MIN_LEN;
      end
      S_PAD: begin
        m_valid_d = 1'b1;
        cnt_d     = cnt_q + 11'd1;
        finish    = cnt_d == MIN_LEN;
      end
      S_FCS: begin
        m_valid_d = 1'b1;
        m_data_d  = fcs_byte;
        m_eof_d   = cnt_q == 11'd3;
        cnt_d     = (cnt_q == 11'd3) ? 11'd0 : cnt_q + 11'd1;
        state_d   = (cnt_q == 11'd3) ? S_IFG : S_FCS;
      end
      S_IFG: begin
        cnt_d   = (cnt_q == IFG_LAST) ? 11'd0 : cnt_q + 11'd1;
        state_d = (cnt_q == IFG_LAST) ? S_IDLE : S_IFG;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      state_d = FCS_EN ? S_FCS : S_IFG;
      cnt_d   = 11'd0;
      m_eof_d = !FCS_EN;
    end
  end

  // Status outputs follow the next state so they line up with the registered stream
  always_comb begin
    s_ready_d   = state_d == S_PAY;
    busy_d      = state_d != S_IDLE;
    frame_cnt_d = frame_cnt_q + 16'(m_eof_d);
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_sof_q     <= 1'b0;
      m_eof_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_sof_q     <= m_sof_d;
      m_eof_q     <= m_eof_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_sof     = m_sof_q;
  assign bus.m_eof     = m_eof_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_oversize  = err_q;

  a_no_stall: assert property (@(posedge clk) disable iff (rst) state_q == S_PAY |-> bus.s_valid)
    else $error("upstream stalled during payload");
endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: table-driven scoreboard bench for eth_frame_tx (untagged and VLAN instances)
module tb_eth_frame_tx;
`ifdef ETH_TX_FCS_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif
  typedef struct {logic [7:0] d; logic s; logic e;} beat_t;
  typedef struct {int k; int len; logic [7:0] base; int exp_len; int exp_err;} vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eth_frame_tx_if bus0();
  eth_frame_tx_if bus1();
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_last = 1'b0;
  int sel = 0;
  logic ready;
  logic busy0, busy1, err0, err1;
  logic [15:0] fc0, fc1;

  assign bus0.s_data  = s_data;
  assign bus0.s_valid = s_valid && sel == 0;
  assign bus0.s_last  = s_last;
  assign bus1.s_data  = s_data;
  assign bus1.s_valid = s_valid && sel == 1;
  assign bus1.s_last  = s_last;
  assign ready = (sel == 0) ? bus0.s_ready : bus1.s_ready;

  eth_frame_tx u0 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .frame_cnt(fc0), .err_oversize(err0));
  eth_frame_tx #(.VLAN_TAG_EN(1'b1), .VLAN_VID(12'h064)) u1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .frame_cnt(fc1), .err_oversize(err1));

  beat_t exp0[$];
  beat_t exp1[$];
  logic [7:0] rxf[$];
  int checks = 0, errors = 0;
  int eof_cnt[2], sof_cyc[2], eof_cyc[2], gap[2], err_cnt[2], rx_bytes[2], fexp[2];
  vec_t tv[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 8; j++) r = (r >> 1) ^ ((r[0] ^ b[j]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic beat(input int k, input logic [7:0] d, input logic s, input logic e);
    beat_t x;
    logic [31:0] c;
    int qs;
    rx_bytes[k]++;
    if (s) begin
      gap[k] = cyc - eof_cyc[k];
      sof_cyc[k] = cyc;
      if (k == 0) rxf.delete();
    end
    if (e) begin
      eof_cyc[k] = cyc;
      eof_cnt[k]++;
    end
    if (k == 0) rxf.push_back(d);
    qs = (k == 0) ? exp0.size() : exp1.size();
    if (qs == 0) begin
      checks++;
      errors++;
      $display("FAIL beat%0d unexpected byte %02h, none expected", k, d);
    end else begin
      if (k == 0) x = exp0.pop_front();
      else x = exp1.pop_front();
      chk($sformatf("beat%0d_%0d {data,sof,eof}", k, rx_bytes[k]), {22'd0, d, s, e}, {22'd0, x.d, x.s, x.e});
    end
`ifdef ETH_TX_FCS_EN
    if (e && k == 0) begin
      c = '1;
      for (int i = 8; i < rxf.size(); i++) c = crc_upd(c, rxf[i]);
      chk("fcs_residue", c, 32'hDEBB20E3);
    end
`endif
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (err0) err_cnt[0]++;
      if (err1) err_cnt[1]++;
      if (bus0.m_valid) beat(0, bus0.m_data, bus0.m_sof, bus0.m_eof);
      if (bus1.m_valid) beat(1, bus1.m_data, bus1.m_sof, bus1.m_eof);
    end

  task automatic push_frame(input int k, input int len, input logic [7:0] base);
    logic [7:0] f[$];
    logic [47:0] dst, src;
    logic [31:0] c;
    beat_t x;
    int n, m;
    dst = 48'h01_00_5E_00_00_01;
    src = 48'h02_00_00_00_00_01;
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    if (k == 1) begin
      f.push_back(8'h81);
      f.push_back(8'h00);
      f.push_back(8'h00);
      f.push_back(8'h64);
    end
    f.push_back(8'h08);
    f.push_back(8'h00);
    n = (len > 1500) ? 1500 : len;
    m = (k == 1) ? 42 : 46;
    for (int i = 0; i < n; i++) f.push_back(base + 8'(i));
    for (int i = n; i < m; i++) f.push_back(8'h00);
`ifdef ETH_TX_FCS_EN
    c = '1;
    for (int i = 8; i < f.size(); i++) c = crc_upd(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
`endif
    for (int i = 0; i < f.size(); i++) begin
      x.d = f[i];
      x.s = i == 0;
      x.e = i == f.size() - 1;
      if (k == 0) exp0.push_back(x);
      else exp1.push_back(x);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_ready_wait_ok", 32'(n < 200), 1);
  endtask

  // call right after a posedge+#1; start returns the cycle s_valid was raised
  task automatic send(input int k, input int len, input logic [7:0] base, output int start);
    sel = k;
    s_valid = 1'b1;
    s_data = base;
    s_last = len == 1;
    start = cyc;
    wait_ready();
    for (int i = 0; i < len; i++) begin
      s_data = base + 8'(i);
      s_last = i == len - 1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_eof(input int k, input int target);
    int n;
    n = 0;
    while (eof_cnt[k] < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("eof_seen%0d", k), 32'(eof_cnt[k]), 32'(target));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int st, rx0, er0, e0;
    tv[0] = '{0, 46,   8'h00, 68 + F, 0};
    tv[1] = '{0, 1,    8'hAA, 68 + F, 0};
    tv[2] = '{0, 45,   8'h30, 68 + F, 0};
    tv[3] = '{0, 47,   8'h40, 69 + F, 0};
    tv[4] = '{0, 1500, 8'h01, 1522 + F, 0};
    tv[5] = '{0, 1501, 8'h07, 1522 + F, 1};
    tv[6] = '{1, 10,   8'h50, 68 + F, 0};
    tv[7] = '{1, 43,   8'h60, 69 + F, 0};

    repeat (3) @(posedge clk); #1;
    chk("rst_flags0", {26'd0, bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.s_ready, busy0, err0}, 0);
    chk("rst_flags1", {26'd0, bus1.m_valid, bus1.m_sof, bus1.m_eof, bus1.s_ready, busy1, err1}, 0);
    chk("rst_data0", {24'd0, bus0.m_data}, 0);
    chk("rst_cnt0", {16'd0, fc0}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy0", {31'd0, busy0}, 0);

    for (int i = 0; i < 8; i++) begin
      push_frame(tv[i].k, tv[i].len, tv[i].base);
      rx0 = rx_bytes[tv[i].k];
      er0 = err_cnt[tv[i].k];
      e0 = eof_cnt[tv[i].k];
      send(tv[i].k, tv[i].len, tv[i].base, st);
      wait_eof(tv[i].k, e0 + 1);
      fexp[tv[i].k]++;
      chk($sformatf("v%0d_sof_latency", i), 32'(sof_cyc[tv[i].k] - st), 1);
      chk($sformatf("v%0d_bytes", i), 32'(rx_bytes[tv[i].k] - rx0), 32'(tv[i].exp_len));
      chk($sformatf("v%0d_err_cycles", i), 32'(err_cnt[tv[i].k] - er0), 32'(tv[i].exp_err));
      chk($sformatf("v%0d_frame_cnt", i), {16'd0, tv[i].k == 0 ? fc0 : fc1}, 32'(fexp[tv[i].k]));
      chk($sformatf("v%0d_queue_left", i), 32'(exp0.size() + exp1.size()), 0);
      repeat (20) @(posedge clk); #1;
    end

    e0 = eof_cnt[0];
    push_frame(0, 46, 8'h00);
    push_frame(0, 20, 8'h80);
    send(0, 46, 8'h00, st);
    send(0, 20, 8'h80, st);
    wait_eof(0, e0 + 2);
    fexp[0] += 2;
    chk("b2b_ifg_gap", 32'(gap[0]), 13);
    chk("b2b_frame_cnt", {16'd0, fc0}, 32'(fexp[0]));
    chk("b2b_queue_left", 32'(exp0.size()), 0);
    repeat (20) @(posedge clk); #1;

    push_frame(0, 30, 8'h20);
    sel = 0;
    s_valid = 1'b1;
    s_data = 8'h20;
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      s_data = 8'h20 + 8'(i);
      @(posedge clk); #1;
    end
    chk("midpay_busy", {31'd0, busy0}, 1);
    rst = 1'b1;
    #1;
    chk("abort_flags", {27'd0, bus0.m_valid, bus0.m_sof, bus0.m_eof, bus0.s_ready, busy0}, 0);
    chk("abort_data", {24'd0, bus0.m_data}, 0);
    chk("abort_frame_cnt", {16'd0, fc0}, 0);
    s_valid = 1'b0;
    exp0.delete();
    e0 = eof_cnt[0];
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_eof", 32'(eof_cnt[0]), 32'(e0));
    push_frame(0, 46, 8'h33);
    send(0, 46, 8'h33, st);
    wait_eof(0, e0 + 1);
    chk("post_rst_frame_cnt", {16'd0, fc0}, 1);
    chk("post_rst_queue_left", 32'(exp0.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
